// File: rtl/mips_pkg.sv
// Shared constants and FSM state type for the micro MIPS register-file access path.
package mips_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } st_e;
endpackage

// File: rtl/wb_fifo.sv
// Write-back buffer: power-of-two FIFO with wrap-bit pointers and a per-entry
// address match vector so the arbiter can spot reads that would bypass a pending write.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push,
    input  logic [AW-1:0]    push_addr,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    input  logic [AW-1:0]    cmp_a1,
    input  logic [AW-1:0]    cmp_a2,
    output logic             full,
    output logic             empty,
    output logic [AW-1:0]    head_addr,
    output logic [DW-1:0]    head_data,
    output logic [DEPTH-1:0] match1,
    output logic [DEPTH-1:0] match2
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [IW-1:0] offs;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign head_addr = addr_mem[rd_ptr[IW-1:0]];
    assign head_data = data_mem[rd_ptr[IW-1:0]];

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        match1 = '0;
        match2 = '0;
        offs   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs      = IW'(i) - rd_ptr[IW-1:0];
            match1[i] = ({1'b0, offs} < count) && (addr_mem[i] == cmp_a1);
            match2[i] = ({1'b0, offs} < count) && (addr_mem[i] == cmp_a2);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            addr_mem[wr_ptr[IW-1:0]] <= push_addr;
            data_mem[wr_ptr[IW-1:0]] <= push_data;
        end
    end
endmodule

// File: rtl/reg_access_ctrl.sv
// Merges decode operand reads and buffered write-backs onto the single register-file port,
// stalling reads that would overtake a pending write and forcing $zero reads to 0.
// Handshakes: a transfer occurs on a cycle where valid and ready are both high; valid
// holds until accepted, ready may depend combinationally on valid; rd_rsp_valid has no backpressure.
module reg_access_ctrl #(
    parameter int WB_DEPTH = 2,
    parameter int AW       = 5,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          res,
    input  logic          rd_req_valid,
    output logic          rd_req_ready,
    input  logic [AW-1:0] rd_a1,
    input  logic [AW-1:0] rd_a2,
    output logic          rd_rsp_valid,
    output logic [DW-1:0] rd_rsp_d1,
    output logic [DW-1:0] rd_rsp_d2,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [AW-1:0] rf_a1,
    output logic [AW-1:0] rf_a2,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd3,
    output logic          rf_we,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output mips_pkg::st_e dbg_st
);
    import mips_pkg::*;

    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

    st_e st, st_nxt;
    logic full, empty;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [WB_DEPTH-1:0] m1, m2;
    logic wb_acc, wb_push, hit1, hit2, hazard;
    logic issue_wr, issue_rd;
    logic rsp_pend, z1, z2, popped_q;

    assign wb_ready = !res && !full;
    assign wb_acc   = wb_valid && wb_ready;
    // Writes to $zero complete the handshake but never reach the register file.
    assign wb_push  = wb_acc && (wb_addr != ZERO_A);

    wb_fifo #(.DEPTH(WB_DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk       (clk),
        .res       (res),
        .push      (wb_push),
        .push_addr (wb_addr),
        .push_data (wb_data),
        .pop       (rf_we),
        .cmp_a1    (rd_a1),
        .cmp_a2    (rd_a2),
        .full      (full),
        .empty     (empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .match1    (m1),
        .match2    (m2)
    );

    assign hit1   = (rd_a1 != ZERO_A) && ((|m1) || (wb_acc && (wb_addr == rd_a1)));
    assign hit2   = (rd_a2 != ZERO_A) && ((|m2) || (wb_acc && (wb_addr == rd_a2)));
    assign hazard = rd_req_valid && (hit1 || hit2);

    always_comb begin
        st_nxt   = st;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        case (st)
            RUN: begin
                issue_wr = !empty && (full || hazard || !rd_req_valid);
                issue_rd = rd_req_valid && !issue_wr && !hazard;
                if (hazard && !empty) st_nxt = DRAIN;
            end
            DRAIN: begin
                issue_wr = !empty;
                // Re-evaluate the hazard once the previous pop has landed.
                if (!hazard && (popped_q || empty)) st_nxt = RUN;
            end
            default: st_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            st       <= RUN;
            rsp_pend <= 1'b0;
            z1       <= 1'b0;
            z2       <= 1'b0;
            popped_q <= 1'b0;
        end else begin
            st       <= st_nxt;
            rsp_pend <= issue_rd;
            popped_q <= issue_wr;
            if (issue_rd) begin
                z1 <= (rd_a1 == ZERO_A);
                z2 <= (rd_a2 == ZERO_A);
            end
        end
    end

    assign rf_we        = issue_wr && !res;
    assign rd_req_ready = issue_rd && !res;
    assign rf_a1        = res ? '0 : rd_a1;
    assign rf_a2        = res ? '0 : rd_a2;
    assign rf_a3        = res ? '0 : head_addr;
    assign rf_wd3       = res ? '0 : head_data;
    assign rd_rsp_valid = rsp_pend && !res;
    assign rd_rsp_d1    = (res || z1) ? '0 : rf_rd1;
    assign rd_rsp_d2    = (res || z2) ? '0 : rf_rd2;
    assign dbg_st       = st;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed and randomized bench for reg_access_ctrl with a behavioural register-file
// slave and an architectural reference of register contents.
module tb_reg_access_ctrl;
    import mips_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int WB_DEPTH = 2;

    logic          clk = 1'b0;
    logic          res;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_a1, rd_a2;
    logic          rd_rsp_valid;
    logic [DW-1:0] rd_rsp_d1, rd_rsp_d2;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rf_a1, rf_a2, rf_a3;
    logic [DW-1:0] rf_wd3;
    logic          rf_we;
    logic [DW-1:0] rf_rd1, rf_rd2;
    st_e           dbg_st;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0]   rf_mem   [32];
    logic [DW-1:0]   init_val [32];
    logic [DW-1:0]   mreg     [32];
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] e;
    logic            preload = 1'b0;
    logic            mon_en  = 1'b0;

    reg_access_ctrl #(.WB_DEPTH(WB_DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .res          (res),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_a1        (rd_a1),
        .rd_a2        (rd_a2),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_d1    (rd_rsp_d1),
        .rd_rsp_d2    (rd_rsp_d2),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rf_a1        (rf_a1),
        .rf_a2        (rf_a2),
        .rf_a3        (rf_a3),
        .rf_wd3       (rf_wd3),
        .rf_we        (rf_we),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .dbg_st       (dbg_st)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // register file slave: registered reads when not writing
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val[i];
        end else if (rf_we) begin
            rf_mem[rf_a3] <= rf_wd3;
        end else begin
            rf_rd1 <= rf_mem[rf_a1];
            rf_rd2 <= rf_mem[rf_a2];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: architectural register state at read acceptance
    always @(negedge clk) begin
        if (preload) for (int i = 0; i < 32; i++) mreg[i] = init_val[i];
        if (mon_en) begin
            if (rd_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rd_rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_d1", rd_rsp_d1, e[2*DW-1:DW]);
                    chk("sb_d2", rd_rsp_d2, e[DW-1:0]);
                end
            end
            if (rd_req_valid && rd_req_ready)
                exp_q.push_back({(rd_a1 == 0) ? 32'h0 : mreg[rd_a1],
                                 (rd_a2 == 0) ? 32'h0 : mreg[rd_a2]});
            if (rf_we) chk("rf_we_addr_nonzero", 32'(rf_a3 == 0), 32'd0);
            if (wb_valid && wb_ready && wb_addr != 0) mreg[wb_addr] = wb_data;
        end
    end

    // driver tasks: start and end just after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        bit ok;
        wb_valid = 1'b1; wb_addr = a; wb_data = d; n = 0; ok = 1'b0;
        while (!ok && n < 20) begin
            smp();
            if (wb_ready) ok = 1'b1;
            else begin n++; step(); end
        end
        if (!ok) chk("wb_accept_timeout", 32'd0, 32'd1);
        else step();
        wb_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           output logic [DW-1:0] d1, output logic [DW-1:0] d2);
        int n;
        bit ok;
        rd_req_valid = 1'b1; rd_a1 = a1; rd_a2 = a2; n = 0; ok = 1'b0;
        d1 = 'x; d2 = 'x;
        while (!ok && n < 20) begin
            smp();
            if (rd_req_ready) ok = 1'b1;
            else begin n++; step(); end
        end
        if (!ok) begin
            chk("rd_accept_timeout", 32'd0, 32'd1);
            rd_req_valid = 1'b0;
        end else begin
            step();
            rd_req_valid = 1'b0;
            smp();
            chk("rd_rsp_valid", 32'(rd_rsp_valid), 32'd1);
            d1 = rd_rsp_d1;
            d2 = rd_rsp_d2;
            step();
        end
    endtask

    initial begin
        logic [DW-1:0] d1, d2;
        logic [DW-1:0] v1, v2, v3;
        int n, rd_wait;
        bit ok, wb_hs, rd_hs;

        for (int i = 0; i < 32; i++) init_val[i] = $urandom;
        init_val[0] = 32'hA5A5_A5A5;
        init_val[9] = 32'hDEAD_BEEF;

        // reset with traffic offered
        res = 1'b1; preload = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
        rd_req_valid = 1'b1; rd_a1 = 5'd3; rd_a2 = 5'd4;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("rst_rf_we", 32'(rf_we), 32'd0);
            chk("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
            chk("rst_rd_ready", 32'(rd_req_ready), 32'd0);
            chk("rst_wb_ready", 32'(wb_ready), 32'd0);
            chk("rst_d1", rd_rsp_d1, 32'd0);
            chk("rst_d2", rd_rsp_d2, 32'd0);
            chk("rst_rf_a1", 32'(rf_a1), 32'd0);
            chk("rst_rf_a3", 32'(rf_a3), 32'd0);
            chk("rst_rf_wd3", rf_wd3, 32'd0);
            step();
        end
        res = 1'b0; preload = 1'b0; wb_valid = 1'b0; rd_req_valid = 1'b0;
        mon_en = 1'b1;
        smp();
        chk("post_rst_st", 32'(dbg_st), 32'(RUN));
        chk("post_rst_rf_we", 32'(rf_we), 32'd0);
        chk("post_rst_wb_ready", 32'(wb_ready), 32'd1);
        step();

        // basic read with $zero on port 2
        do_read(5'd9, 5'd0, d1, d2);
        chk("basic_d1", d1, 32'hDEAD_BEEF);
        chk("basic_d2", d2, 32'd0);

        // idle write appears on the port the next cycle
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h1234;
        smp();
        chk("idle_wb_ready", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        smp();
        chk("idle_rf_we", 32'(rf_we), 32'd1);
        chk("idle_rf_a3", 32'(rf_a3), 32'd10);
        chk("idle_rf_wd3", rf_wd3, 32'h1234);
        step();
        do_read(5'd10, 5'd9, d1, d2);
        chk("idle_readback", d1, 32'h1234);

        // RAW hazard against a write accepted in the same cycle
        wb_valid = 1'b1; wb_addr = 5'd11; wb_data = 32'd5;
        rd_req_valid = 1'b1; rd_a1 = 5'd11; rd_a2 = 5'd0;
        smp();
        chk("raw_stall0", 32'(rd_req_ready), 32'd0);
        chk("raw_wb_acc", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        smp();
        chk("raw_stall1", 32'(rd_req_ready), 32'd0);
        chk("raw_rf_we", 32'(rf_we), 32'd1);
        chk("raw_rf_a3", 32'(rf_a3), 32'd11);
        step();
        smp();
        chk("raw_drain_st", 32'(dbg_st), 32'(DRAIN));
        n = 0; ok = 1'b0;
        while (!ok && n < 8) begin
            if (rd_req_ready) ok = 1'b1;
            else begin n++; step(); smp(); end
        end
        if (!ok) chk("raw_issue_timeout", 32'd0, 32'd1);
        step();
        rd_req_valid = 1'b0;
        smp();
        chk("raw_rsp_valid", 32'(rd_rsp_valid), 32'd1);
        chk("raw_d1", rd_rsp_d1, 32'd5);
        step();

        // unrelated read alongside a write issues without stall
        wb_valid = 1'b1; wb_addr = 5'd11; wb_data = 32'd7;
        rd_req_valid = 1'b1; rd_a1 = 5'd12; rd_a2 = 5'd0;
        smp();
        chk("norel_rd_ready", 32'(rd_req_ready), 32'd1);
        chk("norel_wb_ready", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0; rd_req_valid = 1'b0;
        idle(3);

        // FIFO full under continuous non-conflicting reads
        v1 = $urandom; v2 = $urandom; v3 = $urandom;
        rd_req_valid = 1'b1; rd_a1 = 5'd20; rd_a2 = 5'd21;
        wb_valid = 1'b1; wb_addr = 5'd1; wb_data = v1;
        smp();
        chk("full_wb1", 32'(wb_ready), 32'd1);
        step();
        wb_addr = 5'd2; wb_data = v2;
        smp();
        chk("full_wb2", 32'(wb_ready), 32'd1);
        chk("full_rd_flow", 32'(rd_req_ready), 32'd1);
        step();
        wb_addr = 5'd3; wb_data = v3;
        smp();
        chk("full_wb_ready", 32'(wb_ready), 32'd0);
        chk("full_forces_wr", 32'(rf_we), 32'd1);
        chk("full_rf_a3", 32'(rf_a3), 32'd1);
        n = 0; ok = 1'b0;
        while (!ok && n < 8) begin
            step(); smp();
            if (wb_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) chk("full_wb3_timeout", 32'd0, 32'd1);
        step();
        wb_valid = 1'b0;
        idle(3);
        rd_req_valid = 1'b0;
        idle(5);
        do_read(5'd1, 5'd2, d1, d2);
        chk("full_reg1", d1, v1);
        chk("full_reg2", d2, v2);
        do_read(5'd3, 5'd0, d1, d2);
        chk("full_reg3", d1, v3);

        // $zero write is absorbed
        do_write(5'd0, 32'hFFFF_FFFF);
        smp();
        chk("zero_no_we", 32'(rf_we), 32'd0);
        step();
        do_read(5'd0, 5'd9, d1, d2);
        chk("zero_read", d1, 32'd0);
        chk("zero_read_p2", d2, 32'hDEAD_BEEF);

        // randomized traffic with a narrow address range to provoke hazards
        rd_wait = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!wb_valid && $urandom_range(0, 2) == 0) begin
                wb_valid = 1'b1;
                wb_addr  = AW'($urandom_range(0, 7));
                wb_data  = $urandom;
            end
            if (!rd_req_valid && $urandom_range(0, 1) == 0) begin
                rd_req_valid = 1'b1;
                rd_a1 = AW'($urandom_range(0, 9));
                rd_a2 = AW'($urandom_range(0, 9));
            end
            smp();
            wb_hs = wb_valid && wb_ready;
            rd_hs = rd_req_valid && rd_req_ready;
            if (rd_req_valid && !rd_hs) rd_wait++;
            else rd_wait = 0;
            if (rd_wait == 65) chk("rand_rd_stall_bound", 32'd0, 32'd1);
            step();
            if (wb_hs) wb_valid = 1'b0;
            if (rd_hs) rd_req_valid = 1'b0;
        end
        wb_valid = 1'b0; rd_req_valid = 1'b0;
        idle(10);

        // final architectural state and scoreboard drain
        smp();
        chk("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("end_st", 32'(dbg_st), 32'(RUN));
        chk("end_reg0_untouched", rf_mem[0], 32'hA5A5_A5A5);
        for (int i = 1; i < 32; i++) chk($sformatf("end_reg%0d", i), rf_mem[i], mreg[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
